// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute-stage ALU: opcode codes, default width
// and the skid-buffer state encoding ({skid_valid, main_valid}).
package alu_exec_stage_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: result, zero and, with ALU_FLAGS_EN defined,
// carry/overflow/negative flags.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
`ifdef ALU_FLAGS_EN
  ,output logic           carry
  ,output logic           overflow
  ,output logic           negative
`endif
);

  // NOTE: every output gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_FLAGS_EN
  logic [XLEN:0] sum_ext;
  logic          a_msb, b_msb, r_msb;

  assign sum_ext = {1'b0, src_a} + {1'b0, src_b};
  assign a_msb   = src_a[XLEN-1];
  assign b_msb   = src_b[XLEN-1];
  assign r_msb   = result[XLEN-1];

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        carry    = sum_ext[XLEN];
        overflow = (a_msb == b_msb) && (r_msb != a_msb);
      end
      ALU_SUB: begin
        // Carry on subtract means "no borrow".
        carry    = (src_a >= src_b);
        overflow = (a_msb != b_msb) && (r_msb != a_msb);
      end
      default: ;
    endcase
  end

  assign negative = r_msb;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU followed by a 2-entry skid buffer with valid/ready on
// both sides. Optional flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [2:0]       alu_control,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EN
  ,output logic            carry
  ,output logic            overflow
  ,output logic            negative
`endif
);

  stage_state_e state_q, state_d;
  logic         in_ready_q;
  logic         in_xfer, out_xfer;
  logic         load_main, load_skid, move_skid;

  logic [XLEN-1:0]  core_result, main_result_q, skid_result_q;
  logic             core_zero, main_zero_q, skid_zero_q;
  logic [TAG_W-1:0] main_tag_q, skid_tag_q;

`ifdef ALU_FLAGS_EN
  logic [2:0] core_flags, main_flags_q, skid_flags_q;
`endif

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .result      (core_result),
    .zero        (core_zero)
`ifdef ALU_FLAGS_EN
    ,.carry      (core_flags[2])
    ,.overflow   (core_flags[1])
    ,.negative   (core_flags[0])
`endif
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_xfer) begin
        state_d   = ST_ONE;
        load_main = 1'b1;
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: if (out_xfer) begin
        state_d   = ST_ONE;
        move_skid = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle acceptance; the offered input is dropped.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_result_q <= '0;
      main_zero_q   <= 1'b0;
      main_tag_q    <= '0;
      skid_result_q <= '0;
      skid_zero_q   <= 1'b0;
      skid_tag_q    <= '0;
`ifdef ALU_FLAGS_EN
      main_flags_q  <= '0;
      skid_flags_q  <= '0;
`endif
    end else begin
      if (load_main) begin
        main_result_q <= core_result;
        main_zero_q   <= core_zero;
        main_tag_q    <= in_tag;
`ifdef ALU_FLAGS_EN
        main_flags_q  <= core_flags;
`endif
      end else if (move_skid) begin
        main_result_q <= skid_result_q;
        main_zero_q   <= skid_zero_q;
        main_tag_q    <= skid_tag_q;
`ifdef ALU_FLAGS_EN
        main_flags_q  <= skid_flags_q;
`endif
      end
      if (load_skid) begin
        skid_result_q <= core_result;
        skid_zero_q   <= core_zero;
        skid_tag_q    <= in_tag;
`ifdef ALU_FLAGS_EN
        skid_flags_q  <= core_flags;
`endif
      end
    end
  end

  assign result  = main_result_q;
  assign zero    = main_zero_q;
  assign out_tag = main_tag_q;

`ifdef ALU_FLAGS_EN
  assign carry    = main_flags_q[2];
  assign overflow = main_flags_q[1];
  assign negative = main_flags_q[0];
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; flag checks are included
// when ALU_FLAGS_EN is defined.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [XLEN-1:0]  src_a, src_b, result;
  logic [2:0]       alu_control;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef ALU_FLAGS_EN
  logic             carry, overflow, negative;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .out_tag     (out_tag)
`ifdef ALU_FLAGS_EN
    ,.carry      (carry)
    ,.overflow   (overflow)
    ,.negative   (negative)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    in_valid    = v;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_tag      = t;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t);
    drive(1'b1, op, a, b, t);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] r,
                            input logic z, input logic [4:0] t);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".result"}, result, r);
    check({tag, ".zero"}, 32'(zero), 32'(z));
    check({tag, ".tag"}, 32'(out_tag), 32'(t));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, ALU_ADD, 32'd5, 32'd5, 5'd9);
    #1;

    // Reset held two cycles with in_valid asserted.
    step(); step();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.result", result, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("rst.no_capture", 32'(out_valid), 32'd0);

    // Streaming at full rate.
    send(ALU_ADD, 32'd5, 32'd7, 5'd3);
    expect_out("add", 1'b1, 32'd12, 1'b0, 5'd3);
    drive(1'b1, ALU_SUB, 32'd9, 32'd9, 5'd4); step();
    expect_out("sub", 1'b1, 32'd0, 1'b1, 5'd4);
    drive(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5); step();
    expect_out("slt", 1'b1, 32'd1, 1'b0, 5'd5);
    drive(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd6); step();
    expect_out("and", 1'b1, 32'h0000_00F0, 1'b0, 5'd6);
    drive(1'b1, ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7); step();
    expect_out("or", 1'b1, 32'h0000_FFF0, 1'b0, 5'd7);
    check("or.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd8); step();
    expect_out("slt_neg", 1'b1, 32'd0, 1'b1, 5'd8);
    in_valid = 1'b0; step();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: two entries fill main and skid.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 5'd1);
    expect_out("bp1", 1'b1, 32'd2, 1'b0, 5'd1);
    check("bp1.in_ready", 32'(in_ready), 32'd1);
    send(ALU_ADD, 32'd2, 32'd2, 5'd2);
    expect_out("bp2", 1'b1, 32'd2, 1'b0, 5'd1);
    check("bp2.in_ready", 32'(in_ready), 32'd0);
    step();
    expect_out("bp_hold", 1'b1, 32'd2, 1'b0, 5'd1);
    out_ready = 1'b1; step();
    expect_out("bp_pop", 1'b1, 32'd4, 1'b0, 5'd2);
    check("bp_pop.in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Wrap, overflow, unknown opcodes.
    send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd10);
    expect_out("wrap", 1'b1, 32'd0, 1'b1, 5'd10);
`ifdef ALU_FLAGS_EN
    check("wrap.carry", 32'(carry), 32'd1);
    check("wrap.ovf", 32'(overflow), 32'd0);
    check("wrap.neg", 32'(negative), 32'd0);
`endif
    send(ALU_SUB, 32'h8000_0000, 32'd1, 5'd11);
    expect_out("subovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 5'd11);
`ifdef ALU_FLAGS_EN
    check("subovf.carry", 32'(carry), 32'd1);
    check("subovf.ovf", 32'(overflow), 32'd1);
    check("subovf.neg", 32'(negative), 32'd0);
    send(ALU_SUB, 32'd1, 32'd2, 5'd12);
    check("borrow.carry", 32'(carry), 32'd0);
    check("borrow.neg", 32'(negative), 32'd1);
    check("borrow.result", result, 32'hFFFF_FFFF);
`endif
    send(3'b111, 32'd5, 32'd3, 5'd13);
    expect_out("op111", 1'b1, 32'd0, 1'b1, 5'd13);
    send(3'b100, 32'hFFFF_0000, 32'h0000_FFFF, 5'd14);
    expect_out("op100", 1'b1, 32'd0, 1'b1, 5'd14);
    step();

    // Flush from FULL with a new input offered.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd10, 32'd0, 5'd15);
    send(ALU_ADD, 32'd20, 32'd0, 5'd16);
    check("fl.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, ALU_ADD, 32'd99, 32'd0, 5'd17); step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", 32'(out_valid), 32'd0);
    check("fl.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(); step();
    check("fl.stays_empty", 32'(out_valid), 32'd0);

    // Flush from ONE while an input would be accepted.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd30, 32'd0, 5'd18);
    flush = 1'b1;
    drive(1'b1, ALU_ADD, 32'd40, 32'd0, 5'd19); step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1.out_valid", 32'(out_valid), 32'd0);
    check("fl1.in_ready", 32'(in_ready), 32'd1);

    // Reset while holding one entry.
    send(ALU_ADD, 32'd8, 32'd8, 5'd20);
    check("mr.loaded", 32'(out_valid), 32'd1);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    check("mr.out_valid", 32'(out_valid), 32'd0);
    check("mr.in_ready", 32'(in_ready), 32'd1);
    check("mr.result", result, 32'd0);
    out_ready = 1'b1;
    send(ALU_ADD, 32'd3, 32'd4, 5'd21);
    expect_out("mr.add", 1'b1, 32'd7, 1'b0, 5'd21);
    step();
    check("mr.drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
